// File: rtl/zint_pkg.sv
// Shared types and constants for the Z80 IM2 interrupt responder.
// Holds the responder state encoding and the vector-table address helper.
package zint_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        RD_LO = 3'd2,
        RD_HI = 3'd3,
        LOAD  = 3'd4
    } zack_state_t;

    localparam int ZACK_TICKS_DEFAULT = 6;
    localparam int ZACK_TBL_AW        = 16;

    // Table entry address; the high byte uses a full 16-bit carry so {I,FF}+1 reaches {I+1,00}.
    function automatic logic [ZACK_TBL_AW-1:0] tbl_addr(input logic [7:0] ibase,
                                                        input logic [7:0] vec,
                                                        input logic       hi);
        tbl_addr = {ibase, vec} + {15'd0, hi};
    endfunction

endpackage

// File: rtl/zintack.sv
// IM2 interrupt responder: samples int_n at instruction end, runs the acknowledge
// cycle, reads the 16-bit ISR address from the {I, vector} table and loads the PC.
module zintack
    import zint_pkg::*;
#(
    parameter int ACK_TICKS = ZACK_TICKS_DEFAULT
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        zpos,
    input  logic        insn_end,
    input  logic        int_n,
    input  logic        iff1,
    input  logic        im2,
    input  logic [7:0]  i_reg,
    input  logic [7:0]  im2vect,
    output logic        intack,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_data,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic        busy
);

    localparam logic [3:0] LAST_TICK = 4'(ACK_TICKS - 1);

    zack_state_t state_r, state_s;
    logic [3:0]  tick_r, tick_s;
    logic [7:0]  vec_r, vec_s;
    logic [7:0]  ibase_r, ibase_s;
    logic [7:0]  lo_r, lo_s;
    logic [15:0] pc_new_s;
    logic [15:0] mem_addr_s;
    logic        intack_s, mem_rd_s, pc_load_s, busy_s;

    // Next-state, datapath captures and next values of the registered outputs.
    always_comb begin
        state_s    = state_r;
        tick_s     = tick_r;
        vec_s      = vec_r;
        ibase_s    = ibase_r;
        lo_s       = lo_r;
        pc_new_s   = pc_new;
        mem_addr_s = 16'd0;
        case (state_r)
            IDLE: begin
                if (zpos && insn_end && !int_n && iff1 && im2) begin
                    state_s = ACK;
                    tick_s  = 4'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK: begin
                // The vector is sampled on the final tick, long after the controller settled.
                if (zpos) begin
                    if (tick_r == LAST_TICK) begin
                        vec_s   = im2vect;
                        ibase_s = i_reg;
                        tick_s  = 4'd0;
                        state_s = RD_LO;
                    end else begin
                        tick_s = tick_r + 4'd1;
                    end
                end else begin
                    tick_s = tick_r;
                end
            end
            RD_LO: begin
                if (mem_rdy) begin
                    lo_s    = mem_data;
                    state_s = RD_HI;
                end else begin
                    state_s = RD_LO;
                end
            end
            RD_HI: begin
                if (mem_rdy) begin
                    pc_new_s = {mem_data, lo_r};
                    state_s  = LOAD;
                end else begin
                    state_s = RD_HI;
                end
            end
            LOAD: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            RD_LO:   mem_addr_s = tbl_addr(ibase_s, vec_s, 1'b0);
            RD_HI:   mem_addr_s = tbl_addr(ibase_s, vec_s, 1'b1);
            default: mem_addr_s = 16'd0;
        endcase

        intack_s  = (state_s == ACK);
        mem_rd_s  = (state_s == RD_LO) || (state_s == RD_HI);
        pc_load_s = (state_s == LOAD);
        busy_s    = (state_s != IDLE);
    end

    // State, sequencer registers and registered outputs.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r  <= IDLE;
            tick_r   <= 4'd0;
            vec_r    <= 8'd0;
            ibase_r  <= 8'd0;
            lo_r     <= 8'd0;
            intack   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= 16'd0;
            pc_load  <= 1'b0;
            pc_new   <= 16'd0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_s;
            tick_r   <= tick_s;
            vec_r    <= vec_s;
            ibase_r  <= ibase_s;
            lo_r     <= lo_s;
            intack   <= intack_s;
            mem_rd   <= mem_rd_s;
            mem_addr <= mem_addr_s;
            pc_load  <= pc_load_s;
            pc_new   <= pc_new_s;
            busy     <= busy_s;
        end
    end

endmodule

// File: tb/tb_zintack.sv
// Scoreboard bench for zintack: stimulus pushes expected table reads and ISR
// addresses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_zintack;
    import zint_pkg::*;

    localparam int AT = 6;

    logic        clk = 1'b0, res_n = 1'b0, zpos = 1'b0, insn_end = 1'b0;
    logic        int_n = 1'b1, iff1 = 1'b0, im2 = 1'b0;
    logic [7:0]  i_reg = 8'd0, im2vect = 8'd0, mem_data = 8'd0;
    logic        mem_rdy = 1'b0;
    logic        intack, mem_rd, pc_load, busy;
    logic [15:0] mem_addr, pc_new;

    int checks = 0, errors = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr [$];
    logic [15:0] exp_pc [$];
    int zdiv = 1, zcnt = 0, mem_wait = 0, cyc = 0, trig_cyc = 0;
    bit timed = 1'b0;

    zintack #(.ACK_TICKS(AT)) dut (
        .clk(clk), .res_n(res_n), .zpos(zpos), .insn_end(insn_end),
        .int_n(int_n), .iff1(iff1), .im2(im2), .i_reg(i_reg), .im2vect(im2vect),
        .intack(intack), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
        .mem_data(mem_data), .pc_load(pc_load), .pc_new(pc_new), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    // CPU clock-enable: one zpos cycle every zdiv clk.
    always @(posedge clk) begin
        #1;
        zcnt = (zcnt + 1 >= zdiv) ? 0 : zcnt + 1;
        zpos = (zcnt == 0);
    end

    // Memory responder: mem_rdy after mem_wait extra cycles on a held address; junk data otherwise.
    int r_hcnt = 0;
    logic r_prev_rd = 1'b0, r_prev_rdy = 1'b0;
    logic [15:0] r_prev_addr = 16'd0;
    always @(posedge clk) begin
        #1;
        if (mem_rd) begin
            if (r_prev_rd && !r_prev_rdy && mem_addr == r_prev_addr) r_hcnt++;
            else r_hcnt = 0;
            mem_rdy  = (r_hcnt >= mem_wait);
            mem_data = mem_rdy ? mem[mem_addr] : 8'($urandom);
        end else begin
            r_hcnt   = 0;
            mem_rdy  = 1'($urandom);
            mem_data = 8'($urandom);
        end
        r_prev_rd   = mem_rd;
        r_prev_addr = mem_addr;
        r_prev_rdy  = mem_rdy;
    end

    // Monitor: compares reads, loads and acknowledge length against the scoreboard.
    logic m_prev_rd = 1'b0, m_prev_rdy = 1'b0, m_prev_int = 1'b0, m_prev_load = 1'b0;
    logic [15:0] m_prev_addr = 16'd0;
    int m_hold = 0, zp_cnt = 0;
    always @(negedge clk) begin
        if (!res_n) begin
            m_prev_rd = 1'b0; m_prev_rdy = 1'b0; m_prev_int = 1'b0; m_prev_load = 1'b0;
            m_hold = 0; zp_cnt = 0;
        end else begin
            if (m_prev_rd && !m_prev_rdy)
                check("rd_stable", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, m_prev_addr});
            if (mem_rd) m_hold = (m_prev_rd && !m_prev_rdy) ? m_hold + 1 : 1;
            if (mem_rd && mem_rdy) begin
                if (exp_addr.size() == 0) begin
                    fail($sformatf("unexpected_read actual=%0h required=none", mem_addr));
                end else begin
                    check("rd_addr", {16'd0, mem_addr}, {16'd0, exp_addr.pop_front()});
                    check("rd_hold", m_hold, mem_wait + 1);
                end
            end
            if (pc_load) begin
                check("load_pulse", {31'd0, m_prev_load}, 32'd0);
                if (exp_pc.size() == 0)
                    fail($sformatf("unexpected_load actual=%0h required=none", pc_new));
                else
                    check("pc_new", {16'd0, pc_new}, {16'd0, exp_pc.pop_front()});
                if (timed) check("load_latency", cyc - trig_cyc, AT + 3);
            end
            if (intack && !m_prev_int && timed) check("ack_rise", cyc - trig_cyc, 1);
            if (intack && zpos) zp_cnt++;
            if (!intack && m_prev_int) begin
                check("ack_ticks", zp_cnt, AT);
                zp_cnt = 0;
            end
            m_prev_rd   = mem_rd;
            m_prev_rdy  = mem_rdy;
            m_prev_addr = mem_addr;
            m_prev_int  = intack;
            m_prev_load = pc_load;
        end
    end

    task automatic do_irq(input logic [7:0] i, input logic [7:0] v0, input logic [7:0] v,
                          input logic ni, input logic f, input logic m,
                          input bit glitch, input bit abort);
        bit accept;
        int g;
        logic [15:0] a, ahi;
        accept = !ni && f && m;
        a   = {i, v};
        ahi = a + 16'd1;
        timed = (zdiv == 1) && (mem_wait == 0);
        i_reg = i; im2vect = v0; int_n = ni; iff1 = f; im2 = m;
        g = 0;
        do begin @(posedge clk); #2; g++; end while (!zpos && g < 100);
        insn_end = 1'b1;
        trig_cyc = cyc;
        if (accept) begin
            exp_addr.push_back(a);
            exp_addr.push_back(ahi);
            exp_pc.push_back({mem[ahi], mem[a]});
        end
        @(posedge clk); #2;
        insn_end = 1'b0;
        int_n = 1'b1;
        if (!accept) begin
            check("reject_idle", {29'd0, busy, intack, mem_rd}, 32'd0);
            repeat (4) @(posedge clk);
            #2;
            check("reject_stay", {29'd0, busy, intack, mem_rd}, 32'd0);
            return;
        end
        if (v0 != v) begin
            repeat (2) @(posedge clk);
            #2;
            im2vect = v;
        end
        if (glitch) begin
            g = 0;
            do begin @(posedge clk); #2; g++; end while (!zpos && g < 100);
            insn_end = 1'b1; int_n = 1'b0;
            @(posedge clk); #2;
            insn_end = 1'b0; int_n = 1'b1;
        end
        if (abort) begin
            g = 0;
            do begin @(negedge clk); g++; end while (!(mem_rd && mem_addr == ahi) && g < 500);
            if (g >= 500) fail("abort_wait timeout");
            #2;
            res_n = 1'b0;
            #1;
            check("reset_async", {12'd0, intack, mem_rd, pc_load, busy, mem_addr}, 32'd0);
            check("reset_pc", {16'd0, pc_new}, 32'd0);
            exp_addr.delete();
            exp_pc.delete();
            @(negedge clk);
            @(posedge clk); #2;
            res_n = 1'b1;
        end
        g = 0;
        while (busy && g < 3000) begin @(posedge clk); #2; g++; end
        if (g >= 3000) fail("busy timeout");
        repeat (2) @(posedge clk);
        #2;
        check("queue_empty", exp_addr.size() + exp_pc.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
        mem[16'h5BFF] = 8'h34;
        mem[16'h5C00] = 8'h12;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out", {12'd0, intack, mem_rd, pc_load, busy, mem_addr}, 32'd0);
        check("reset_pcnew", {16'd0, pc_new}, 32'd0);
        res_n = 1'b1;
        repeat (2) @(posedge clk);

        zdiv = 1; mem_wait = 0;
        do_irq(8'h5B, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("basic_pc", {16'd0, pc_new}, 32'h1234);

        do_irq(8'h5B, 8'h10, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_irq(8'h5B, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_irq(8'h5B, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        do_irq(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_irq(8'h12, 8'hFD, 8'hFD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        mem_wait = 3;
        do_irq(8'h3C, 8'h42, 8'h42, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        zdiv = 4; mem_wait = 0;
        do_irq(8'h80, 8'h11, 8'hA7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        zdiv = 1; mem_wait = 3;
        do_irq(8'h44, 8'h20, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        mem_wait = 0;
        do_irq(8'h44, 8'h20, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_irq(8'h09, 8'hE0, 8'hE0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            logic [7:0] ri, rv;
            ri = 8'($urandom);
            rv = 8'($urandom);
            zdiv = $urandom_range(1, 3);
            mem_wait = $urandom_range(0, 3);
            do_irq(ri, rv, rv, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                   ($urandom_range(0, 5) != 0), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zintack.md
# zintack

CPU-side IM2 interrupt responder for the TS-Conf Z80 core: the consumer end of the `int_n`/`intack`/`im2vect` interface driven by the interrupt controller. At an instruction boundary it samples `int_n`. If the request is honoured, it runs the acknowledge cycle and latches the 8-bit vector from the controller. It then fetches the 16-bit ISR address from the IM2 table at `{I, vector}` over a simple memory-read handshake and hands the result to the CPU's PC loader.

## Interface
Parameters:
- ACK_TICKS, 6: number of `zpos` ticks `intack` stays asserted (acknowledge M1 length incl. auto-waits); legal 2..15

Ports:
- clk  in  1  system clock
- res_n  in  1  reset, asynchronous, active-low
- zpos  in  1  Z80 clock-enable strobe (rising CPU clock phase), one `clk` wide
- insn_end  in  1  last-T-state strobe of current instruction; qualified by `zpos`
- int_n  in  1  maskable interrupt request, active-low
- iff1  in  1  CPU interrupt-enable flip-flop
- im2  in  1  CPU is in interrupt mode 2
- i_reg  in  8  CPU I register
- im2vect  in  8  vector supplied by the interrupt controller
- intack  out  1  acknowledge cycle in progress (M1 & IORQ)
- mem_rd  out  1  table read request
- mem_addr  out  16  table read address
- mem_rdy  in  1  read data valid / request accepted
- mem_data  in  8  read data
- pc_load  out  1  one-`clk` pulse: `pc_new` valid
- pc_new  out  16  ISR address, {hi, lo}
- busy  out  1  sequence active (any state but IDLE)

## Operation
- States: IDLE, ACK, RD_LO, RD_HI, LOAD.
- **IDLE → ACK** on `zpos && insn_end && !int_n && iff1 && im2`. Otherwise stay in IDLE; no output changes.
- **ACK**
  - `intack`=1.
  - 4-bit tick counter counts `zpos` pulses. On the ACK_TICKS-th pulse, in that same `clk`:
    - latch `vec <= im2vect` and `ibase <= i_reg`;
    - go to RD_LO.
- **RD_LO**
  - `mem_rd`=1, `mem_addr`={ibase, vec}.
  - On a `clk` with `mem_rdy`=1: capture `lo <= mem_data`, go to RD_HI.
- **RD_HI**
  - `mem_rd`=1, `mem_addr`={ibase, vec}+1. This is a full 16-bit increment: FFFF wraps to 0000, and {I,FF} becomes {I+1,00}.
  - On `mem_rdy`: capture hi, go to LOAD.
- **LOAD**
  - `pc_load`=1 for one `clk`, `pc_new`={hi, lo}; go to IDLE.
  - `pc_new` holds until the next LOAD.
- `int_n`, `iff1` and `im2` are ignored outside IDLE; the controller's latched priority selection is trusted.
- `insn_end` strobes while `busy` are ignored; there is no re-trigger or queueing.
- `mem_rdy` in IDLE or ACK is ignored.
- Reset (`res_n` low, any state, including mid-read):
  - immediately IDLE;
  - all outputs 0: `intack`, `mem_rd`, `mem_addr`, `pc_load`, `pc_new`, `busy`;
  - tick counter cleared.
  - A read aborted by reset is never completed.

## Timing
- All outputs are registered.
- Trigger at `clk` T gives `intack`=`busy`=1 from T+1.
- `intack` high duration:
  - exactly ACK_TICKS `zpos` pulses, counted from the first `zpos` after entering ACK;
  - deasserts on the `clk` after the final pulse;
  - with `zpos` every `clk`: high T+1..T+ACK_TICKS.
- `intack` always returns low for at least one `clk` before any later assertion. Minimum IDLE dwell is 1 `clk` after LOAD, which guarantees the controller sees a fresh rising edge.
- The vector is latched ≥ACK_TICKS−1 `clk` after the `intack` rise, well after the controller has updated its selection.
- `mem_rd` and `mem_addr` are stable from request until the `mem_rdy` cycle inclusive. `mem_rd` drops or changes address on the following `clk`.
- Zero-wait memory: RD_LO 1 `clk`, RD_HI 1 `clk`, LOAD 1 `clk`.
- End-to-end with `zpos` every `clk` and zero-wait memory: `pc_load` at T+ACK_TICKS+3.

## Structure
- Shared package `zint_pkg`: state enum typedef `zack_state_t`, default `ACK_TICKS` constant, IM2 table-address width constant (16).
- Single module; the tick counter and read sequencer are simple enough to stay inline. No sub-module.

## Test plan
- **Basic sequence.** `zpos` every `clk`, zero-wait memory, I=5B, `im2vect`=FF, mem[5BFF]=34, mem[5C00]=12. Trigger → `intack` high 6 `clk`, reads at 5BFF then 5C00, `pc_load` pulse with `pc_new`=1234, `busy` then 0.
- **Rejected requests.** `insn_end` with `int_n`=1, or `iff1`=0, or `im2`=0 → no `intack`, `busy` stays 0, no reads.
- **Address wrap.** I=FF, `im2vect`=FF → reads at FFFF then 0000. Also I=12, vect=FD → 12FD, 12FE.
- **Wait states.** `mem_rdy` delayed 3 `clk` on each read → `mem_rd` and `mem_addr` held constant 4 `clk` per byte; data captured only on the `mem_rdy` cycle; correct `pc_new`.
- **Slow CPU clock.** `zpos` every 4th `clk`, ACK_TICKS=6 → `intack` high ≈24 `clk`. `im2vect` changed 2 `clk` after the `intack` rise → the new value is used.
- **Reset and re-trigger.** `res_n` pulsed low during RD_HI → all outputs 0 asynchronously. The next trigger completes normally. An `insn_end` + `int_n`=0 strobe during ACK is ignored, giving exactly one `pc_load`.
